// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// default frame geometry and the number of arbitrated requesters.
package uart_pkg;

  localparam int UART_DEF_DATA_W       = 8;
  localparam int UART_DEF_CLKS_PER_BIT = 16;
  localparam int UART_NUM_REQ          = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period. A restart pulse re-aligns the count to zero.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_restart,
  output logic        o_tick,
  output logic [15:0] o_cnt
);

  localparam logic [15:0] LP_TERM = 16'(CLKS_PER_BIT - 1);

  logic [15:0] r_cnt;

  // Baud counter: wraps at terminal count, parked at zero when disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 16'd0;
    end else if (i_restart) begin
      r_cnt <= 16'd0;
    end else if (i_en) begin
      if (r_cnt == LP_TERM) begin
        r_cnt <= 16'd0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end else begin
      r_cnt <= 16'd0;
    end
  end

  assign o_tick = i_en && (r_cnt == LP_TERM);
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Two-requester UART transmitter. A round-robin arbiter picks a payload in
// IDLE, the FSM serialises START / DATA (LSB first) / optional even PARITY /
// STOP, and all line-side outputs are registered from the next-state values
// so they line up with the state register.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT,
  parameter int DATA_W       = UART_DEF_DATA_W,
  parameter int PARITY_EN    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [UART_NUM_REQ-1:0] req,
  input  logic [DATA_W-1:0]       data0,
  input  logic [DATA_W-1:0]       data1,
  output logic [UART_NUM_REQ-1:0] gnt,
  output logic                    tx,
  output logic                    wr_en,
  output logic                    busy,
  output logic                    done
);

  localparam int             LP_BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [LP_BIT_W-1:0] LP_BIT_LAST = LP_BIT_W'(DATA_W - 1);
  localparam logic [15:0]    LP_PRE_TERM = 16'(CLKS_PER_BIT - 2);

  // Even parity bit over the payload.
  function automatic logic calc_even_parity(input logic [DATA_W-1:0] d);
    calc_even_parity = ^d;
  endfunction

  uart_tx_state_e        r_state;
  uart_tx_state_e        w_state_next;
  logic [DATA_W-1:0]     r_shift;
  logic [DATA_W-1:0]     w_shift_next;
  logic [LP_BIT_W-1:0]   r_bit;
  logic [LP_BIT_W-1:0]   w_bit_next;
  logic                  r_par;
  logic                  r_last;
  logic                  r_tx;
  logic                  r_wr_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_tx_next;
  logic                  w_done_next;
  logic [UART_NUM_REQ-1:0] w_gnt;
  logic [DATA_W-1:0]     w_sel_data;
  logic                  w_tick;
  logic [15:0]           w_baud_cnt;
  logic                  w_baud_en;
  logic                  w_any_gnt;

  // Round-robin arbiter, only live in IDLE and never while reset is held.
  always_comb begin
    w_gnt = 2'b00;
    if (!reset && (r_state == ST_IDLE)) begin
      case (req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end else begin
      w_gnt = 2'b00;
    end
  end

  assign w_any_gnt  = |w_gnt;
  assign w_sel_data = w_gnt[1] ? data1 : data0;
  assign w_baud_en  = (r_state != ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_baud_en),
    .i_restart(w_any_gnt),
    .o_tick   (w_tick),
    .o_cnt    (w_baud_cnt)
  );

  // Next-state, shifter and bit-counter logic.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_bit_next   = r_bit;
    case (r_state)
      ST_IDLE: begin
        if (w_any_gnt) begin
          w_state_next = ST_START;
          w_shift_next = w_sel_data;
          w_bit_next   = '0;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_next = ST_DATA;
        end else begin
          w_state_next = ST_START;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit == LP_BIT_LAST) begin
            w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            w_bit_next   = '0;
          end else begin
            w_bit_next   = r_bit + LP_BIT_W'(1);
            w_shift_next = {1'b0, r_shift[DATA_W-1:1]};
          end
        end else begin
          w_state_next = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_state_next = ST_STOP;
        end else begin
          w_state_next = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_STOP;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, derived from the state being entered.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_shift_next[0];
      ST_PARITY: w_tx_next = r_par;
      default:   w_tx_next = 1'b1;
    endcase
  end

  // done lands in the last STOP cycle, so it is armed one cycle earlier.
  assign w_done_next = (r_state == ST_STOP) && (w_baud_cnt == LP_PRE_TERM);

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_par   <= 1'b0;
      r_last  <= 1'b1;
      r_tx    <= 1'b1;
      r_wr_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_bit   <= w_bit_next;
      if (w_any_gnt) begin
        r_par  <= calc_even_parity(w_sel_data);
        r_last <= w_gnt[1];
      end else begin
        r_par  <= r_par;
        r_last <= r_last;
      end
      r_tx    <= w_tx_next;
      r_wr_en <= (w_state_next != ST_IDLE);
      r_busy  <= (w_state_next != ST_IDLE);
      r_done  <= w_done_next;
    end
  end

  assign gnt   = w_gnt;
  assign tx    = r_tx;
  assign wr_en = r_wr_en;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with CLKS_PER_BIT=4, DATA_W=8, plus a
// second instance with the parity bit disabled.
module tb_uart_tx_scheduler;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [7:0] data0, data1;
  logic [1:0] gnt;
  logic       tx, wr_en, busy, done;

  logic [1:0] req_np;
  logic [7:0] data0_np, data1_np;
  logic [1:0] gnt_np;
  logic       tx_np, wr_en_np, busy_np, done_np;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_scheduler #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1)) dut (
    .clk(clk), .reset(reset), .req(req), .data0(data0), .data1(data1),
    .gnt(gnt), .tx(tx), .wr_en(wr_en), .busy(busy), .done(done)
  );

  uart_tx_scheduler #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(0)) dut_np (
    .clk(clk), .reset(reset), .req(req_np), .data0(data0_np), .data1(data1_np),
    .gnt(gnt_np), .tx(tx_np), .wr_en(wr_en_np), .busy(busy_np), .done(done_np)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records one frame starting in the cycle after gnt: tx per bit (first
  // cycle of the bit), cycles where tx moved inside a bit, wr_en/done/gnt
  // activity. Optionally pulses req[1] for two cycles at frame cycle pulse_at.
  task automatic capture(input bit use_np, input int nbits, input int pulse_at,
                         output logic [15:0] bits, output int wr_cnt,
                         output int done_cyc, output int done_cnt,
                         output int gnt_seen, output int unstable);
    int n;
    logic t_s, w_s, d_s;
    logic [1:0] g_s;
    n = nbits * CPB;
    bits = 16'h0000; wr_cnt = 0; done_cyc = 0; done_cnt = 0;
    gnt_seen = 0; unstable = 0;
    for (int k = 1; k <= n; k++) begin
      if (pulse_at != 0 && k == pulse_at) req = 2'b10;
      if (pulse_at != 0 && k == pulse_at + 2) req = 2'b00;
      #1;
      t_s = use_np ? tx_np : tx;
      w_s = use_np ? wr_en_np : wr_en;
      d_s = use_np ? done_np : done;
      g_s = use_np ? gnt_np : gnt;
      if ((k - 1) % CPB == 0) bits[(k - 1) / CPB] = t_s;
      else if (t_s !== bits[(k - 1) / CPB]) unstable++;
      if (w_s === 1'b1) wr_cnt++;
      if (d_s === 1'b1) begin done_cnt++; done_cyc = k; end
      if (g_s !== 2'b00) gnt_seen++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b11; data0 = 8'h00; data1 = 8'h00;
    req_np = 2'b00; data0_np = 8'h00; data1_np = 8'h00;
    step(); step(); step();
    n_checks++; if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt); else n_pass++;
    n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
    n_checks++; if ({wr_en, busy, done} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {wr_en, busy, done}); else n_pass++;
    step();
    n_checks++; if (gnt !== 2'b00) $display("FAIL reset_held_gnt: got %b want 00", gnt); else n_pass++;
    req = 2'b00;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    logic [15:0] bits; int wr_cnt, done_cyc, done_cnt, gnt_seen, unstable;
    req = 2'b01; data0 = 8'hA5;
    #1;
    n_checks++; if (gnt !== 2'b01) $display("FAIL single_gnt: got %b want 01", gnt); else n_pass++;
    n_checks++; if (tx !== 1'b1) $display("FAIL single_tx_at_gnt: got %b want 1", tx); else n_pass++;
    step();
    req = 2'b00;
    capture(1'b0, 11, 0, bits, wr_cnt, done_cyc, done_cnt, gnt_seen, unstable);
    n_checks++; if (bits[10:0] !== 11'b10101001010) $display("FAIL single_bits: got %b want 10101001010", bits[10:0]); else n_pass++;
    n_checks++; if (unstable !== 0) $display("FAIL single_stable: got %0d want 0", unstable); else n_pass++;
    n_checks++; if (wr_cnt !== 44) $display("FAIL single_wr_en: got %0d want 44", wr_cnt); else n_pass++;
    n_checks++; if (done_cyc !== 44 || done_cnt !== 1) $display("FAIL single_done: got cyc %0d cnt %0d want 44/1", done_cyc, done_cnt); else n_pass++;
    n_checks++; if (gnt_seen !== 0) $display("FAIL single_gnt_busy: got %0d want 0", gnt_seen); else n_pass++;
    #1;
    n_checks++; if ({tx, wr_en, busy, done} !== 4'b1000) $display("FAIL single_after: got %b want 1000", {tx, wr_en, busy, done}); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits; int wr_cnt, done_cyc, done_cnt, gnt_seen, unstable;
    reset = 1'b1;
    step();
    reset = 1'b0; req = 2'b11; data0 = 8'h00; data1 = 8'hFF;
    #1;
    n_checks++; if (gnt !== 2'b01) $display("FAIL b2b_gnt1: got %b want 01", gnt); else n_pass++;
    step();
    capture(1'b0, 11, 0, bits, wr_cnt, done_cyc, done_cnt, gnt_seen, unstable);
    n_checks++; if (bits[10:0] !== 11'b10000000000) $display("FAIL b2b_bits1: got %b want 10000000000", bits[10:0]); else n_pass++;
    n_checks++; if (done_cyc !== 44 || gnt_seen !== 0) $display("FAIL b2b_frame1: got done %0d gnts %0d want 44/0", done_cyc, gnt_seen); else n_pass++;
    #1;
    n_checks++; if (gnt !== 2'b10) $display("FAIL b2b_gnt2: got %b want 10", gnt); else n_pass++;
    n_checks++; if ({tx, busy} !== 2'b10) $display("FAIL b2b_idle: got %b want 10", {tx, busy}); else n_pass++;
    step();
    capture(1'b0, 11, 0, bits, wr_cnt, done_cyc, done_cnt, gnt_seen, unstable);
    n_checks++; if (bits[10:0] !== 11'b10111111110) $display("FAIL b2b_bits2: got %b want 10111111110", bits[10:0]); else n_pass++;
    n_checks++; if (bits[9] !== 1'b0) $display("FAIL b2b_parity2: got %b want 0", bits[9]); else n_pass++;
    n_checks++; if (unstable !== 0 || wr_cnt !== 44) $display("FAIL b2b_frame2: got unstable %0d wr %0d want 0/44", unstable, wr_cnt); else n_pass++;
    #1;
    n_checks++; if (gnt !== 2'b01) $display("FAIL b2b_gnt3: got %b want 01", gnt); else n_pass++;
    req = 2'b00;
    step();
  endtask

  task automatic test_req_ignored();
    logic [15:0] bits; int wr_cnt, done_cyc, done_cnt, gnt_seen, unstable;
    req = 2'b01; data0 = 8'h3C;
    #1;
    n_checks++; if (gnt !== 2'b01) $display("FAIL ign_gnt: got %b want 01", gnt); else n_pass++;
    step();
    req = 2'b00;
    capture(1'b0, 11, 10, bits, wr_cnt, done_cyc, done_cnt, gnt_seen, unstable);
    n_checks++; if (bits[10:0] !== 11'b10001111000) $display("FAIL ign_bits: got %b want 10001111000", bits[10:0]); else n_pass++;
    n_checks++; if (gnt_seen !== 0) $display("FAIL ign_gnt_busy: got %0d want 0", gnt_seen); else n_pass++;
    #1;
    n_checks++; if (gnt !== 2'b00) $display("FAIL ign_gnt_idle: got %b want 00", gnt); else n_pass++;
    step(); step(); step();
    n_checks++; if ({tx, wr_en, busy} !== 3'b100) $display("FAIL ign_idle_line: got %b want 100", {tx, wr_en, busy}); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] bits; int wr_cnt, done_cyc, done_cnt, gnt_seen, unstable;
    int dones;
    req = 2'b01; data0 = 8'h5A;
    #1;
    n_checks++; if (gnt !== 2'b01) $display("FAIL rst_mid_gnt: got %b want 01", gnt); else n_pass++;
    step();
    req = 2'b00;
    for (int i = 0; i < 17; i++) step();
    #1;
    n_checks++; if ({busy, tx} !== 2'b11) $display("FAIL rst_mid_bit3: got %b want 11", {busy, tx}); else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if ({tx, busy, wr_en, done} !== 4'b1000) $display("FAIL rst_mid_abort: got %b want 1000", {tx, busy, wr_en, done}); else n_pass++;
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      if (done === 1'b1 || tx !== 1'b1) dones++;
      step();
    end
    n_checks++; if (dones !== 0) $display("FAIL rst_mid_quiet: got %0d want 0", dones); else n_pass++;
    req = 2'b10; data1 = 8'hC3;
    #1;
    n_checks++; if (gnt !== 2'b10) $display("FAIL rst_mid_regnt: got %b want 10", gnt); else n_pass++;
    step();
    req = 2'b00;
    capture(1'b0, 11, 0, bits, wr_cnt, done_cyc, done_cnt, gnt_seen, unstable);
    n_checks++; if (bits[10:0] !== 11'b10110000110) $display("FAIL rst_mid_bits: got %b want 10110000110", bits[10:0]); else n_pass++;
    n_checks++; if (done_cyc !== 44 || wr_cnt !== 44) $display("FAIL rst_mid_frame: got done %0d wr %0d want 44/44", done_cyc, wr_cnt); else n_pass++;
    step();
  endtask

  task automatic test_no_parity();
    logic [15:0] bits; int wr_cnt, done_cyc, done_cnt, gnt_seen, unstable;
    req_np = 2'b01; data0_np = 8'h81;
    #1;
    n_checks++; if (gnt_np !== 2'b01) $display("FAIL np_gnt: got %b want 01", gnt_np); else n_pass++;
    step();
    req_np = 2'b00;
    capture(1'b1, 10, 0, bits, wr_cnt, done_cyc, done_cnt, gnt_seen, unstable);
    n_checks++; if (bits[9:0] !== 10'b1100000010) $display("FAIL np_bits: got %b want 1100000010", bits[9:0]); else n_pass++;
    n_checks++; if (unstable !== 0) $display("FAIL np_stable: got %0d want 0", unstable); else n_pass++;
    n_checks++; if (wr_cnt !== 40 || done_cyc !== 40) $display("FAIL np_len: got wr %0d done %0d want 40/40", wr_cnt, done_cyc); else n_pass++;
    #1;
    n_checks++; if ({tx_np, busy_np} !== 2'b10) $display("FAIL np_after: got %b want 10", {tx_np, busy_np}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_req_ignored();
    test_reset_mid_frame();
    test_no_parity();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
